board_tile_fetcher: RTL and testbench
=====================================

Name: board_tile_fetcher

Overview:
- Read-side client of the board-state BlockRAM; the CPU is the writer on port 1, this block reads on port 2.
- Converts the VGA scan position into a board tile address and issues a synchronous read.
- Decodes the returned tile word and presents pixel-aligned tile attributes to the VGA pixel colouring logic.
- Also latches the player cursor once per frame and flags pixels inside the cursor tile.

Parameters:
- TILE_LOG2, 5, log2 of tile edge in pixels (32 px tiles)
- BOARD_COLS, 16, tiles per row
- BOARD_ROWS, 12, tile rows
- ORIGIN_X, 64, first board pixel column
- ORIGIN_Y, 48, first board pixel row
- BASE_ADDR, 0, RAM word address of tile (0,0)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- x  in  10  current scan column, 0..639
- y  in  9  current scan row, 0..479
- active  in  1  scan position is inside the visible area
- cursor_x  in  10  cursor tile top-left pixel x
- cursor_y  in  9  cursor tile top-left pixel y
- ram_addr  out  12  BlockRAM port-2 address (addr2)
- ram_data  in  32  BlockRAM port-2 read data (dataOut2), valid 1 cycle after ram_addr
- px_valid  out  1  outputs below describe a board pixel
- tile_revealed  out  1  word bit 0
- tile_flagged  out  1  word bit 1
- tile_mine  out  1  word bit 2
- tile_count  out  4  word bits [6:3], neighbour mines 0..8
- tile_px_x  out  5  pixel offset within tile, x
- tile_px_y  out  5  pixel offset within tile, y
- tile_edge  out  1  offset is 0 or 31 on either axis (grid line)
- cursor_hit  out  1  pixel lies in the latched cursor tile

Behaviour:
- Pipeline stage S0 (registered), evaluated on each clock:
  - in_board = active && x >= ORIGIN_X && x < ORIGIN_X + (BOARD_COLS << TILE_LOG2), with the same test on y against ORIGIN_Y and BOARD_ROWS.
  - col = (x - ORIGIN_X) >> TILE_LOG2; row = (y - ORIGIN_Y) >> TILE_LOG2.
  - Offsets are the low TILE_LOG2 bits of (x - ORIGIN_X) and (y - ORIGIN_Y).
  - If in_board: ram_addr <= BASE_ADDR + row*BOARD_COLS + col, truncated to 12 bits. If not in_board: ram_addr holds its previous value.
- Stage S1: in_board, offsets and cursor match are delayed one register so they align with ram_data.
- Stage S2 (output registers):
  - px_valid <= delayed in_board.
  - Tile fields are decoded from ram_data when px_valid would be 1; all fields and cursor_hit are forced to 0 otherwise.
  - tile_count values 9..15 pass through unchanged; the consumer treats them as invalid.
- Latency: an x/y pair presented at edge N produces its outputs after edge N+3. Throughput is one pixel per clock.
- Cursor latch:
  - Loaded only on a clock where x==0 && y==0: cur_col = (cursor_x - ORIGIN_X) >> TILE_LOG2, cur_row likewise.
  - A cursor position outside the board latches a tile index that never matches, so cursor_hit stays 0.
  - cursor_hit = in_board && col==cur_col && row==cur_row, evaluated in S0 and delayed with the pipeline.
  - Cursor changes mid-frame have no effect until the next frame start (no tearing).
- Boundaries:
  - x = ORIGIN_X + 512 (576) and y = ORIGIN_Y + 384 (432) are outside the board.
  - active=0 forces in_board=0 at any position.
  - Column wrap: col 15 followed by the next row's col 0 gives address +1 continuity across the row stride (row*16 + 15, then (row+1)*16).
- The CPU may write a word on port 1 during a port-2 read of the same address; the old or new value is acceptable, and the value is correct next frame.
- Reset:
  - ram_addr = BASE_ADDR; all output registers = 0; pipeline in_board registers cleared.
  - cur_col = cur_row = all ones (no cursor match).
  - Reset asserted mid-frame gives outputs 0 on the next cycle. The first valid px_valid appears 3 cycles after reset deasserts with active board input.

Test Plan:
- Reset, then x=64, y=48, active=1 -> ram_addr=0 after 1 edge; with ram_data=0x0000002B, after 3 edges: px_valid=1, revealed=1, flagged=1, mine=0, count=5, px_x=0, px_y=0, tile_edge=1.
- x=100, y=200, active=1 -> ram_addr = 4*16+1 = 65; px_x=4, px_y=24, tile_edge=0.
- x=575 then 576 at y=431 -> first gives ram_addr=191, px_valid=1, px_x=31, tile_edge=1; second gives px_valid=0, ram_addr held at 191, fields 0.
- cursor_x=96, cursor_y=80 applied, then x=0, y=0 frame start -> cursor_hit=1 only for x 96..127, y 80..111. Changing cursor_x to 128 mid-frame does not move the highlight until the next x=0, y=0.
- Board pixel with active=0 -> px_valid=0 and all fields 0 regardless of ram_data=0xFFFFFFFF.
- Stream a row of x=64..575, then assert reset at x=300 -> outputs 0 on the next edge. After release, valid outputs resume 3 edges after the first in-board pixel.

Source files
------------

// File: rtl/board_tile_fetcher.sv
// board_tile_fetcher: maps the VGA scan position to a board tile address,
// reads the tile word from the board BlockRAM (port 2), and presents decoded,
// pixel-aligned tile attributes plus a per-frame latched cursor highlight.
// Pipeline: S0 address/position, S1 alignment with RAM read, S2 decode.
module board_tile_fetcher #(
  parameter int unsigned TILE_LOG2  = 5,
  parameter int unsigned BOARD_COLS = 16,
  parameter int unsigned BOARD_ROWS = 12,
  parameter int unsigned ORIGIN_X   = 64,
  parameter int unsigned ORIGIN_Y   = 48,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [9:0]           x,
  input  logic [8:0]           y,
  input  logic                 active,
  input  logic [9:0]           cursor_x,
  input  logic [8:0]           cursor_y,
  output logic [11:0]          ram_addr,
  input  logic [31:0]          ram_data,
  output logic                 px_valid,
  output logic                 tile_revealed,
  output logic                 tile_flagged,
  output logic                 tile_mine,
  output logic [3:0]           tile_count,
  output logic [TILE_LOG2-1:0] tile_px_x,
  output logic [TILE_LOG2-1:0] tile_px_y,
  output logic                 tile_edge,
  output logic                 cursor_hit
);

  localparam int unsigned X_W   = 10;
  localparam int unsigned Y_W   = 9;
  localparam int unsigned A_W   = 12;
  localparam int unsigned OFF_W = TILE_LOG2;
  localparam int unsigned COL_W = X_W - TILE_LOG2;
  localparam int unsigned ROW_W = Y_W - TILE_LOG2;
  localparam int unsigned X_END = ORIGIN_X + (BOARD_COLS << TILE_LOG2);
  localparam int unsigned Y_END = ORIGIN_Y + (BOARD_ROWS << TILE_LOG2);

  // S0 combinational position decode
  logic [X_W-1:0]   dx;
  logic [Y_W-1:0]   dy;
  logic [X_W-1:0]   cdx;
  logic [Y_W-1:0]   cdy;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             in_board_c;
  logic             hit_c;
  logic             frame_start_c;

  // latched cursor tile
  logic [COL_W-1:0] cur_col;
  logic [ROW_W-1:0] cur_row;

  // pipeline registers
  logic             s0_in, s1_in;
  logic [OFF_W-1:0] s0_px, s0_py, s1_px, s1_py;
  logic             s0_hit, s1_hit;

  // upper word bits carry no tile attributes
  logic             unused_data;

  // Scan position to tile column/row, offsets, and cursor match
  always_comb begin
    dx            = x - X_W'(ORIGIN_X);
    dy            = y - Y_W'(ORIGIN_Y);
    cdx           = cursor_x - X_W'(ORIGIN_X);
    cdy           = cursor_y - Y_W'(ORIGIN_Y);
    col           = dx[X_W-1:TILE_LOG2];
    row           = dy[Y_W-1:TILE_LOG2];
    in_board_c    = active
                    && (32'(x) >= ORIGIN_X) && (32'(x) < X_END)
                    && (32'(y) >= ORIGIN_Y) && (32'(y) < Y_END);
    hit_c         = in_board_c && (col == cur_col) && (row == cur_row);
    frame_start_c = (x == '0) && (y == '0);
    unused_data   = ^ram_data[31:7];
  end

  // Cursor tile latched only at frame start so the highlight never tears
  always_ff @(posedge clock) begin
    if (reset) begin
      cur_col <= '1;
      cur_row <= '1;
    end else if (frame_start_c) begin
      cur_col <= cdx[X_W-1:TILE_LOG2];
      cur_row <= cdy[Y_W-1:TILE_LOG2];
    end
  end

  // S0: issue RAM address for board pixels; hold it off-board
  always_ff @(posedge clock) begin
    if (reset) begin
      ram_addr <= A_W'(BASE_ADDR);
      s0_in    <= 1'b0;
      s0_px    <= '0;
      s0_py    <= '0;
      s0_hit   <= 1'b0;
    end else begin
      if (in_board_c) begin
        ram_addr <= A_W'(BASE_ADDR + 32'(row) * BOARD_COLS + 32'(col));
      end
      s0_in  <= in_board_c;
      s0_px  <= dx[OFF_W-1:0];
      s0_py  <= dy[OFF_W-1:0];
      s0_hit <= hit_c;
    end
  end

  // S1: delay position info to line up with the RAM read data
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_in  <= 1'b0;
      s1_px  <= '0;
      s1_py  <= '0;
      s1_hit <= 1'b0;
    end else begin
      s1_in  <= s0_in;
      s1_px  <= s0_px;
      s1_py  <= s0_py;
      s1_hit <= s0_hit;
    end
  end

  // S2: decode tile word; everything zero outside the board
  always_ff @(posedge clock) begin
    if (reset || !s1_in) begin
      px_valid      <= 1'b0;
      tile_revealed <= 1'b0;
      tile_flagged  <= 1'b0;
      tile_mine     <= 1'b0;
      tile_count    <= '0;
      tile_px_x     <= '0;
      tile_px_y     <= '0;
      tile_edge     <= 1'b0;
      cursor_hit    <= 1'b0;
    end else begin
      px_valid      <= 1'b1;
      tile_revealed <= ram_data[0];
      tile_flagged  <= ram_data[1];
      tile_mine     <= ram_data[2];
      tile_count    <= ram_data[6:3];
      tile_px_x     <= s1_px;
      tile_px_y     <= s1_py;
      tile_edge     <= (s1_px == '0) || (s1_px == '1)
                    || (s1_py == '0) || (s1_py == '1);
      cursor_hit    <= s1_hit;
    end
  end

endmodule

// File: tb/tb_board_tile_fetcher.sv
// Directed bench for board_tile_fetcher with a synchronous BlockRAM model.
module tb_board_tile_fetcher;

  logic        clock = 1'b0;
  logic        reset;
  logic [9:0]  x;
  logic [8:0]  y;
  logic        active;
  logic [9:0]  cursor_x;
  logic [8:0]  cursor_y;
  logic [11:0] ram_addr;
  logic [31:0] ram_data;
  logic        px_valid, tile_revealed, tile_flagged, tile_mine;
  logic [3:0]  tile_count;
  logic [4:0]  tile_px_x, tile_px_y;
  logic        tile_edge, cursor_hit;

  logic [31:0] mem [4096];
  logic        force_ff;
  int          total = 0;
  int          bad   = 0;

  board_tile_fetcher dut (
    .clock(clock), .reset(reset), .x(x), .y(y), .active(active),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .ram_addr(ram_addr),
    .ram_data(ram_data), .px_valid(px_valid), .tile_revealed(tile_revealed),
    .tile_flagged(tile_flagged), .tile_mine(tile_mine), .tile_count(tile_count),
    .tile_px_x(tile_px_x), .tile_px_y(tile_px_y), .tile_edge(tile_edge),
    .cursor_hit(cursor_hit)
  );

  always #5 clock = ~clock;

  // synchronous-read BlockRAM port 2
  always @(posedge clock) ram_data <= force_ff ? 32'hFFFF_FFFF : mem[ram_addr];

  function automatic logic [31:0] pk(input logic v, r, f, m, input logic [3:0] c,
                                     input logic [4:0] px, py, input logic e, h);
    return {12'd0, v, r, f, m, c, px, py, e, h};
  endfunction

  function automatic logic [31:0] outs();
    return pk(px_valid, tile_revealed, tile_flagged, tile_mine, tile_count,
              tile_px_x, tile_px_y, tile_edge, cursor_hit);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic probe_hit(input string tag, input int px, input int py, input logic exp);
    x = 10'(px); y = 9'(py); active = 1'b1;
    tick(); tick(); tick();
    check(tag, 32'(cursor_hit), 32'(exp));
  endtask

  initial begin
    force_ff = 1'b0; reset = 1'b1; x = '0; y = '0; active = 1'b0;
    cursor_x = '0; cursor_y = '0;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    mem[0]   = 32'h0000_002B;
    mem[65]  = 32'h0000_0011;
    mem[191] = 32'h0000_004C;
    tick(); tick();
    check("rst_out", outs(), 32'h0);
    check("rst_addr", 32'(ram_addr), 32'd0);
    reset = 1'b0;

    // first board pixel, tile (0,0)
    x = 10'd64; y = 9'd48; active = 1'b1;
    tick();
    check("t1_addr", 32'(ram_addr), 32'd0);
    tick(); tick();
    check("t1_out", outs(), pk(1, 1, 1, 0, 4'd5, 5'd0, 5'd0, 1, 0));

    // interior pixel, tile (1,4)
    x = 10'd100; y = 9'd200;
    tick();
    check("t2_addr", 32'(ram_addr), 32'd65);
    tick(); tick();
    check("t2_out", outs(), pk(1, 1, 0, 0, 4'd2, 5'd4, 5'd24, 0, 0));

    // last board pixel, count 9 passes through
    x = 10'd575; y = 9'd431;
    tick();
    check("t3_addr", 32'(ram_addr), 32'd191);
    tick(); tick();
    check("t3_out", outs(), pk(1, 0, 0, 1, 4'd9, 5'd31, 5'd31, 1, 0));

    // one past right edge
    x = 10'd576;
    tick();
    check("t4_addr_hold", 32'(ram_addr), 32'd191);
    tick(); tick();
    check("t4_out", outs(), 32'h0);

    // bottom edge is outside
    x = 10'd100; y = 9'd432;
    tick(); tick(); tick();
    check("t5_bottom", outs(), 32'h0);

    // active low on a board pixel with all-ones RAM data
    force_ff = 1'b1;
    x = 10'd100; y = 9'd200; active = 1'b0;
    tick(); tick(); tick();
    check("t6_inactive", outs(), 32'h0);
    force_ff = 1'b0;

    // column wrap across row stride
    active = 1'b1; x = 10'd575; y = 9'd79;
    tick();
    check("wrap_a", 32'(ram_addr), 32'd15);
    x = 10'd64; y = 9'd80;
    tick();
    check("wrap_b", 32'(ram_addr), 32'd16);

    // cursor at tile (1,1)
    cursor_x = 10'd96; cursor_y = 9'd80;
    x = 10'd0; y = 9'd0;
    tick();
    probe_hit("cur_in", 100, 90, 1'b1);
    probe_hit("cur_tl", 96, 80, 1'b1);
    probe_hit("cur_br", 127, 111, 1'b1);
    probe_hit("cur_left", 95, 90, 1'b0);
    probe_hit("cur_right", 128, 90, 1'b0);
    probe_hit("cur_below", 100, 112, 1'b0);
    cursor_x = 10'd128;
    probe_hit("cur_notear_old", 100, 90, 1'b1);
    probe_hit("cur_notear_new", 130, 90, 1'b0);
    x = 10'd0; y = 9'd0;
    tick();
    probe_hit("cur_moved_new", 130, 90, 1'b1);
    probe_hit("cur_moved_old", 100, 90, 1'b0);
    cursor_x = 10'd0; cursor_y = 9'd0;
    x = 10'd0; y = 9'd0;
    tick();
    probe_hit("cur_offboard", 64, 48, 1'b0);

    // stream a row, then reset mid-line
    y = 9'd48; active = 1'b1;
    for (int xi = 64; xi <= 300; xi++) begin
      x = 10'(xi);
      tick();
      check("stream_addr", 32'(ram_addr), 32'((xi - 64) >> 5));
    end
    x = 10'd301; reset = 1'b1;
    tick();
    check("midrst_out", outs(), 32'h0);
    check("midrst_addr", 32'(ram_addr), 32'd0);
    reset = 1'b0; x = 10'd64; y = 9'd48;
    tick();
    check("rel_e1", 32'(px_valid), 32'd0);
    tick();
    check("rel_e2", 32'(px_valid), 32'd0);
    tick();
    check("rel_e3", outs(), pk(1, 1, 1, 0, 4'd5, 5'd0, 5'd0, 1, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
